// File: rtl/fu_pkg.sv
// Shared constants and helpers for the execute-stage forwarding/hazard unit.
package fu_pkg;

  localparam int CAUSE_LOAD    = 0;
  localparam int CAUSE_MC_DEP  = 1;
  localparam int CAUSE_MC_FULL = 2;
  localparam int SEL_RF        = 0;

  // Width needed to encode "register file" plus one code per forwarding stage.
  function automatic int sel_width(input int num_stg);
    int w;
    w = 1;
    while ((1 << w) < (num_stg + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mc_slot.sv
// One multi-cycle scoreboard entry: load, countdown, completion flag and
// register-match outputs for a set of query addresses.
module mc_slot #(
  parameter int REG_AW    = 5,
  parameter int LAT_W     = 4,
  parameter int REG0_ZERO = 1,
  parameter int NUM_Q     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [REG_AW-1:0]       load_rdst,
  input  logic [LAT_W-1:0]        load_cnt,
  input  logic [NUM_Q*REG_AW-1:0] q_reg,
  output logic                    valid,
  output logic                    done,
  output logic                    free,
  output logic [REG_AW-1:0]       rdst,
  output logic [NUM_Q-1:0]        q_hit
);

  localparam logic [LAT_W-1:0]  CNT_ONE  = LAT_W'(1);
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  logic              valid_r;
  logic [REG_AW-1:0] rdst_r;
  logic [LAT_W-1:0]  cnt_r;

  assign valid = valid_r;
  assign rdst  = rdst_r;
  assign done  = valid_r && (cnt_r == CNT_ONE);
  assign free  = !valid_r || done;

  // Entry state: a load wins over the completion of the previous occupant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      rdst_r  <= REG_ZERO;
      cnt_r   <= {LAT_W{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      rdst_r  <= load_rdst;
      cnt_r   <= load_cnt;
    end else if (valid_r) begin
      if (cnt_r > CNT_ONE) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        valid_r <= 1'b0;
      end
    end
  end

  for (genvar q = 0; q < NUM_Q; q++) begin : g_match
    logic [REG_AW-1:0] r_s;
    assign r_s      = q_reg[q*REG_AW +: REG_AW];
    assign q_hit[q] = valid_r && (rdst_r == r_s) && !((REG0_ZERO != 0) && (r_s == REG_ZERO));
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Execute-stage forwarding select, load-use detection and a multi-cycle op
// scoreboard producing RAW/WAW/structural stalls plus a stall statistic.
module fwd_hazard_unit
  import fu_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int NUM_STG   = 2,
  parameter int REG_AW    = 5,
  parameter int REG0_ZERO = 1,
  parameter int MC_SLOTS  = 2,
  parameter int LAT_W     = 4,
  parameter int STAT_W    = 16,
  parameter int SEL_W     = sel_width(NUM_STG)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        id_need,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_STG-1:0]        stg_we,
  input  logic [NUM_STG*REG_AW-1:0] stg_rdst,
  input  logic [NUM_STG-1:0]        stg_is_load,
  input  logic                      flush,
  input  logic                      mc_issue,
  input  logic [REG_AW-1:0]         mc_rdst,
  input  logic [LAT_W-1:0]          mc_lat,
  input  logic                      stat_clr,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [2:0]                stall_cause,
  output logic                      mc_busy,
  output logic                      mc_done,
  output logic [REG_AW-1:0]         mc_done_rdst,
  output logic [STAT_W-1:0]         stall_cnt
);

  localparam int                NUM_Q    = NUM_SRC + 1;
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  logic [NUM_SRC-1:0] ld_use_s;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    logic [REG_AW-1:0]  rs_s;
    logic [NUM_STG-1:0] hit_s;
    logic [SEL_W-1:0]   sel_s;
    logic               ld_s;

    assign rs_s = id_rs[j*REG_AW +: REG_AW];

    for (genvar i = 0; i < NUM_STG; i++) begin : g_stg
      assign hit_s[i] = id_need[j] && stg_we[i] &&
                        (stg_rdst[i*REG_AW +: REG_AW] == rs_s) &&
                        !((REG0_ZERO != 0) && (rs_s == REG_ZERO));
    end

    // Priority encode: scan from oldest so the youngest hit overwrites.
    always_comb begin
      sel_s = SEL_W'(SEL_RF);
      ld_s  = 1'b0;
      for (int i = NUM_STG - 1; i >= 0; i--) begin
        sel_s = hit_s[i] ? SEL_W'(i + 1) : sel_s;
        ld_s  = hit_s[i] ? stg_is_load[i] : ld_s;
      end
    end

    assign fwd_sel[j*SEL_W +: SEL_W] = sel_s;
    assign ld_use_s[j]               = ld_s;
  end

  logic [MC_SLOTS-1:0] valid_s;
  logic [MC_SLOTS-1:0] done_s;
  logic [MC_SLOTS-1:0] free_s;
  logic [MC_SLOTS-1:0] load_s;
  logic [MC_SLOTS-1:0] free_oh_s;
  logic [REG_AW-1:0]   slot_rdst_s [MC_SLOTS];
  logic [NUM_Q-1:0]    slot_hit_s  [MC_SLOTS];
  logic [LAT_W-1:0]    lat_eff_s;
  logic                accept_s;

  assign lat_eff_s = (mc_lat == {LAT_W{1'b0}}) ? LAT_W'(1) : mc_lat;

  for (genvar s = 0; s < MC_SLOTS; s++) begin : g_slot
    mc_slot #(
      .REG_AW    (REG_AW),
      .LAT_W     (LAT_W),
      .REG0_ZERO (REG0_ZERO),
      .NUM_Q     (NUM_Q)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_s[s]),
      .load_rdst (mc_rdst),
      .load_cnt  (lat_eff_s),
      .q_reg     ({mc_rdst, id_rs}),
      .valid     (valid_s[s]),
      .done      (done_s[s]),
      .free      (free_s[s]),
      .rdst      (slot_rdst_s[s]),
      .q_hit     (slot_hit_s[s])
    );
  end

  logic dep_s;
  logic full_s;
  logic [2:0] cause_raw_s;

  // RAW on needed operands, WAW on the issuing destination, and slot availability.
  always_comb begin
    dep_s  = 1'b0;
    full_s = mc_issue;
    for (int s = 0; s < MC_SLOTS; s++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        dep_s = dep_s | (id_need[j] & slot_hit_s[s][j]);
      end
      dep_s  = dep_s | (mc_issue & slot_hit_s[s][NUM_SRC]);
      full_s = full_s & ~free_s[s];
    end
  end

  // Cause vector before flush masking.
  always_comb begin
    cause_raw_s                = 3'b000;
    cause_raw_s[CAUSE_LOAD]    = |ld_use_s;
    cause_raw_s[CAUSE_MC_DEP]  = dep_s;
    cause_raw_s[CAUSE_MC_FULL] = full_s;
  end

  assign stall_cause = flush ? 3'b000 : cause_raw_s;
  assign stall       = |stall_cause;
  assign accept_s    = mc_issue && !stall && !flush;

  // Lowest-index free slot as a one-hot and lowest-index completing destination.
  always_comb begin
    logic found_v;
    found_v      = 1'b0;
    free_oh_s    = {MC_SLOTS{1'b0}};
    mc_done_rdst = REG_ZERO;
    for (int s = 0; s < MC_SLOTS; s++) begin
      free_oh_s[s] = free_s[s] & ~found_v;
      found_v      = found_v | free_s[s];
    end
    for (int s = MC_SLOTS - 1; s >= 0; s--) begin
      mc_done_rdst = done_s[s] ? slot_rdst_s[s] : mc_done_rdst;
    end
  end

  assign load_s  = accept_s ? free_oh_s : {MC_SLOTS{1'b0}};
  assign mc_busy = |valid_s;
  assign mc_done = |done_s;

  logic [STAT_W-1:0] stall_cnt_r;
  assign stall_cnt = stall_cnt_r;

  // Saturating stall statistic; clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {STAT_W{1'b0}};
    end else if (stat_clr) begin
      stall_cnt_r <= {STAT_W{1'b0}};
    end else if (stall && (stall_cnt_r != {STAT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + STAT_W'(1);
    end
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the execute stage, sitting beside the ID/EX register. It selects forwarding sources for up to NUM_SRC operands from NUM_STG downstream pipeline stages, with the youngest stage winning. It detects load-use hazards and tracks in-flight multi-cycle operations (mul/div) in a small scoreboard, raising RAW, WAW and structural stalls. It also keeps a saturating stall-cycle statistic.

## Interface
Parameters:
- NUM_SRC, 2: source operands per instruction
- NUM_STG, 2: forwarding stages; stage 0 = EX/MEM (youngest), NUM_STG-1 = oldest (MEM/WB)
- REG_AW, 5: register address width
- REG0_ZERO, 1: if 1, register 0 never matches any hazard or forward
- MC_SLOTS, 2: scoreboard entries for multi-cycle ops
- LAT_W, 4: latency counter width
- STAT_W, 16: stall counter width
- SEL_W, derived: clog2(NUM_STG+1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_need  in  NUM_SRC  operand i is read by the ID/EX instruction
- id_rs  in  NUM_SRC*REG_AW  operand register addresses, operand i at slice i
- stg_we  in  NUM_STG  stage i writes a register
- stg_rdst  in  NUM_STG*REG_AW  stage i destination
- stg_is_load  in  NUM_STG  stage i result still comes from memory and cannot be forwarded
- flush  in  1  ID/EX instruction squashed this cycle
- mc_issue  in  1  ID/EX instruction is a multi-cycle op
- mc_rdst  in  REG_AW  its destination
- mc_lat  in  LAT_W  its latency in cycles; 0 is treated as 1
- stat_clr  in  1  synchronous clear of stall_cnt
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = stage k-1
- stall  out  1  hold ID/EX and upstream stages
- stall_cause  out  3  bit0 load-use, bit1 mc dependency, bit2 mc full
- mc_busy  out  1  any scoreboard entry valid
- mc_done  out  1  an entry completes at the next edge
- mc_done_rdst  out  REG_AW  destination of the lowest-index completing entry
- stall_cnt  out  STAT_W  saturating count of stalled cycles

## Operation
- Hit on stage i for operand j: id_need[j] && stg_we[i] && stg_rdst[i]==id_rs[j], and not (REG0_ZERO && id_rs[j]==0).
- fwd_sel[j] = (lowest i with a hit) + 1; 0 if there is no hit.
- Load-use: the selected stage has stg_is_load set. This sets cause bit0, and fwd_sel still reports that stage.
- Scoreboard entry: valid, rdst, cnt[LAT_W].
  - An entry matches a register r when it is valid, rdst==r, and r is not exempt under REG0_ZERO.
- Mc dependency (cause bit1): any needed operand matches an entry (RAW), or mc_issue && mc_rdst matches an entry (WAW).
- Free slot: invalid, or cnt==1 (completing this cycle).
- Mc full (cause bit2): mc_issue with no free slot.
- stall = OR of the cause bits, forced to 0 (causes 0) when flush=1.
- Accepted issue: mc_issue && !stall && !flush.
  - It loads the lowest-index free slot: valid=1, rdst=mc_rdst, cnt=max(mc_lat,1).
- Each valid entry with cnt>1 decrements every cycle. An entry with cnt==1 clears at the edge unless it is reloaded by the same edge's issue.
- mc_done = any valid entry with cnt==1. mc_done_rdst is 0 when mc_done=0.
- stall_cnt:
  - stat_clr has priority and clears the counter.
  - Otherwise it increments when stall=1 and saturates at all-ones.

## Timing
- fwd_sel, stall, stall_cause, mc_done and mc_done_rdst are combinational from the inputs and registered state, in the same cycle.
- Scoreboard and stall_cnt update on the rising clk edge.
- Reset (async assert, sync-safe release): all entries invalid, stall_cnt=0.
  - Hence mc_busy=0, mc_done=0, mc_done_rdst=0, and cause bits 1 and 2 are 0.
  - fwd_sel and cause bit0 still follow the inputs.
- Reset mid-operation drops every pending entry immediately. Any stall caused by the scoreboard deasserts asynchronously.
- Mc latency L, issue accepted at edge E0:
  - Dependent consumers stall for cycles E0..E0+L-1.
  - mc_done is high in the cycle before the entry clears.
  - The consumer proceeds in the cycle after the edge E0+L, when the register file holds the result (write-first).
- Issue into a slot completing at the same edge is legal and keeps full throughput.

## Structure
- Shared package fu_pkg holds:
  - cause bit indices CAUSE_LOAD=0, CAUSE_MC_DEP=1, CAUSE_MC_FULL=2
  - SEL_RF=0
  - a function for the SEL_W computation
- One sub-module, mc_slot: a single scoreboard entry with load, decrement, completion and match outputs, instantiated MC_SLOTS times.
- Priority encoders and match logic live in generate loops in the top level.

## Test plan
- Forwarding priority:
  - stg_we=2'b11, both stg_rdst=5, id_rs[0]=5, id_need=2'b01 -> fwd_sel[0]=1, stall=0.
  - With only stage 1 writing -> fwd_sel[0]=2.
  - With no writer -> 0.
- Load-use: stage 0 is a load to r7, id_rs[1]=7 needed -> stall=1, cause=3'b001.
  - Next cycle the load is in stage 1 with stg_is_load=0 -> fwd_sel[1]=2, stall=0.
- Register 0: REG0_ZERO=1, stage 0 writes r0, operand r0 needed -> fwd_sel=0, no stall.
  - An mc issue with mc_rdst=0 never blocks consumers.
- Mc RAW, lat 4, rdst r9, consumer needing r9 right after issue -> stall=1 with cause 3'b010 for exactly 4 cycles.
  - mc_done=1 and mc_done_rdst=9 in the 4th cycle.
  - Stall releases in the 5th cycle.
- Mc full: MC_SLOTS=2, two accepted issues at lat 15 and lat 3, then a third issue held -> cause 3'b100.
  - It is accepted on the edge where the lat-3 entry has cnt==1.
  - flush=1 with any hazard -> stall=0.
- Stall counter: STAT_W=4, 20 stalled cycles -> stall_cnt=15.
  - stat_clr -> 0.
  - Asserting rst_n=0 with two valid entries -> mc_busy=0 immediately.
